// File: rtl/pac_pkg.sv
// Shared types and map constants for the Pac-Man movement controller.
// PAC_TURN_QUEUE_EN adds the desired-direction probe states.
package pac_pkg;

  localparam int unsigned MAP_COLS = 32;
  localparam int unsigned MAP_ROWS = 24;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_CUR,
    CK_CUR,
    DONE
`ifdef PAC_TURN_QUEUE_EN
    , RD_DES,
    CK_DES
`endif
  } state_t;

endpackage

// File: rtl/pac_next_pos.sv
// Candidate tile for one step in a direction; horizontal wraps mod 2^ADDR_WIDTH,
// vertical moves off the map are flagged instead of computed.
module pac_next_pos
  import pac_pkg::*;
#(
  parameter int unsigned ROWS       = MAP_ROWS,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] x,
  input  logic [ADDR_WIDTH-1:0] y,
  input  dir_t                  dir,
  output logic [ADDR_WIDTH-1:0] cand_x,
  output logic [ADDR_WIDTH-1:0] cand_y,
  output logic                  out_of_range
);

  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);

  always_comb begin
    cand_x       = x;
    cand_y       = y;
    out_of_range = 1'b0;
    case (dir)
      DIR_UP: begin
        if (y == '0) out_of_range = 1'b1;
        else         cand_y = y - ONE;
      end
      DIR_DOWN: begin
        if (y >= LAST_ROW) out_of_range = 1'b1;
        else               cand_y = y + ONE;
      end
      DIR_LEFT:  cand_x = x - ONE;
      DIR_RIGHT: cand_x = x + ONE;
      default: ;
    endcase
  end

endmodule

// File: rtl/pac_move_ctrl.sv
// Tick-driven movement controller probing the wall ROM before committing a step.
// Optional PAC_TURN_QUEUE_EN: queued turn is probed first, falling back to cur_dir.
module pac_move_ctrl
  import pac_pkg::*;
#(
  parameter int unsigned COLS       = MAP_COLS,
  parameter int unsigned ROWS       = MAP_ROWS,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned START_X    = 13,
  parameter int unsigned START_Y    = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [1:0]            dir_in,
  input  logic                  dir_valid,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COLS-1:0]       rom_data,
  output logic [ADDR_WIDTH-1:0] pos_x,
  output logic [ADDR_WIDTH-1:0] pos_y,
  output logic [1:0]            cur_dir,
  output logic                  moving,
  output logic                  busy,
  output logic                  move_done
);

  state_t                state, state_d;
  dir_t                  cur_dir_q;
  logic [ADDR_WIDTH-1:0] cand_x, cand_y;
  logic [ADDR_WIDTH-1:0] cur_cx, cur_cy;
  logic                  cur_oor;
  logic [COLS-1:0]       row_rev;
  dir_t                  step_dir;

  // ROM MSB is column 0; reversing lets the column index the row directly.
  assign row_rev = {<<{rom_data}};

`ifdef PAC_TURN_QUEUE_EN
  dir_t                  pending_q, pend_eff, des_dir_q;
  logic [ADDR_WIDTH-1:0] des_x, des_y, des_cx, des_cy;
  logic                  des_oor, cur_oor_q;

  assign pend_eff = dir_valid ? dir_t'(dir_in) : pending_q;
  assign step_dir = cur_dir_q;

  pac_next_pos #(.ROWS(ROWS), .ADDR_WIDTH(ADDR_WIDTH)) u_des (
    .x(pos_x), .y(pos_y), .dir(pend_eff),
    .cand_x(des_cx), .cand_y(des_cy), .out_of_range(des_oor)
  );
`else
  assign step_dir = (state == IDLE && dir_valid) ? dir_t'(dir_in) : cur_dir_q;
`endif

  pac_next_pos #(.ROWS(ROWS), .ADDR_WIDTH(ADDR_WIDTH)) u_cur (
    .x(pos_x), .y(pos_y), .dir(step_dir),
    .cand_x(cur_cx), .cand_y(cur_cy), .out_of_range(cur_oor)
  );

  assign cur_dir   = cur_dir_q;
  assign move_done = (state == DONE);

  always_comb begin
    state_d  = state;
    rom_addr = pos_y;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
`ifdef PAC_TURN_QUEUE_EN
          if (pend_eff != cur_dir_q && !des_oor) state_d = RD_DES;
          else
`endif
          state_d = cur_oor ? DONE : RD_CUR;
        end
      end
      RD_CUR: begin
        rom_addr = cand_y;
        busy     = 1'b1;
        state_d  = CK_CUR;
      end
      CK_CUR: begin
        rom_addr = cand_y;
        busy     = 1'b1;
        state_d  = DONE;
      end
`ifdef PAC_TURN_QUEUE_EN
      RD_DES: begin
        rom_addr = des_y;
        busy     = 1'b1;
        state_d  = CK_DES;
      end
      CK_DES: begin
        rom_addr = des_y;
        busy     = 1'b1;
        if (!row_rev[des_x] || cur_oor_q) state_d = DONE;
        else                              state_d = RD_CUR;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pos_x     <= ADDR_WIDTH'(START_X);
      pos_y     <= ADDR_WIDTH'(START_Y);
      cur_dir_q <= DIR_LEFT;
      moving    <= 1'b0;
      cand_x    <= '0;
      cand_y    <= '0;
`ifdef PAC_TURN_QUEUE_EN
      pending_q <= DIR_LEFT;
      des_dir_q <= DIR_LEFT;
      des_x     <= '0;
      des_y     <= '0;
      cur_oor_q <= 1'b0;
`endif
    end else begin
      state <= state_d;
`ifdef PAC_TURN_QUEUE_EN
      if (dir_valid) pending_q <= dir_t'(dir_in);
`endif
      case (state)
        IDLE: begin
`ifndef PAC_TURN_QUEUE_EN
          if (dir_valid) cur_dir_q <= step_dir;
`endif
          if (tick) begin
            cand_x <= cur_cx;
            cand_y <= cur_cy;
`ifdef PAC_TURN_QUEUE_EN
            des_x     <= des_cx;
            des_y     <= des_cy;
            des_dir_q <= pend_eff;
            cur_oor_q <= cur_oor;
`endif
            // Off-map candidate skips the ROM entirely.
            if (state_d == DONE) moving <= 1'b0;
          end
        end
        CK_CUR: begin
          if (!row_rev[cand_x]) begin
            pos_x  <= cand_x;
            pos_y  <= cand_y;
            moving <= 1'b1;
          end else begin
            moving <= 1'b0;
          end
        end
`ifdef PAC_TURN_QUEUE_EN
        CK_DES: begin
          if (!row_rev[des_x]) begin
            pos_x     <= des_x;
            pos_y     <= des_y;
            cur_dir_q <= des_dir_q;
            moving    <= 1'b1;
          end else if (cur_oor_q) begin
            moving <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Directed bench for pac_move_ctrl: one instance on a small maze at (13,20),
// one on an open top row starting at (0,0) for wrap and off-map cases.
module tb_pac_move_ctrl;

  logic        clk = 1'b0;
  logic        reset, reset0;
  logic        tick, tick0, dir_valid, dir_valid0;
  logic [1:0]  dir_in, dir_in0;
  logic [4:0]  rom_addr, rom_addr0, pos_x, pos_y, pos_x0, pos_y0;
  logic [31:0] rom_data, rom_data0;
  logic [1:0]  cur_dir, cur_dir0;
  logic        moving, busy, move_done, moving0, busy0, move_done0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pac_move_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .dir_in(dir_in), .dir_valid(dir_valid),
    .rom_addr(rom_addr), .rom_data(rom_data), .pos_x(pos_x), .pos_y(pos_y),
    .cur_dir(cur_dir), .moving(moving), .busy(busy), .move_done(move_done)
  );

  pac_move_ctrl #(.START_X(0), .START_Y(0)) dut0 (
    .clk(clk), .reset(reset0), .tick(tick0), .dir_in(dir_in0), .dir_valid(dir_valid0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .pos_x(pos_x0), .pos_y(pos_y0),
    .cur_dir(cur_dir0), .moving(moving0), .busy(busy0), .move_done(move_done0)
  );

  // Row 20 open in columns 12..20, row 19 open only at column 12, all else wall.
  function automatic logic [31:0] map_row(input logic [4:0] r);
    logic [31:0] v;
    v = '1;
    if (r == 5'd20) for (int c = 12; c <= 20; c++) v[31-c] = 1'b0;
    if (r == 5'd19) v[31-12] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    rom_data  <= map_row(rom_addr);
    rom_data0 <= (rom_addr0 == 5'd0) ? 32'h0 : 32'hFFFF_FFFF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned pulses;

  initial begin
    reset = 1'b1; reset0 = 1'b1;
    tick = 1'b0; tick0 = 1'b0; dir_valid = 1'b0; dir_valid0 = 1'b0;
    dir_in = 2'd2; dir_in0 = 2'd2;
    step(); step();
    reset = 1'b0; reset0 = 1'b0;

    check("rst_x", pos_x, 13);
    check("rst_y", pos_y, 20);
    check("rst_dir", cur_dir, 2);
    check("rst_moving", moving, 0);
    check("rst_busy", busy, 0);
    check("rst_done", move_done, 0);
    check("rst_addr", rom_addr, 20);

`ifdef PAC_TURN_QUEUE_EN
    // Queue UP at (13,20): row 19 col 13 is wall, so LEFT is taken instead.
    dir_valid = 1'b1; dir_in = 2'd0;
    step();
    dir_valid = 1'b0;
    check("q_dir_hold", cur_dir, 2);
    tick = 1'b1;
    step(); tick = 1'b0;
    check("q_des_addr", rom_addr, 19);
    step(); step();
    check("q_cur_addr", rom_addr, 20);
    check("q_busy", busy, 1);
    step();
    check("q_done_early", move_done, 0);
    step();
    check("q_done5", move_done, 1);
    check("q_x1", pos_x, 12);
    check("q_y1", pos_y, 20);
    check("q_dir1", cur_dir, 2);
    check("q_mov1", moving, 1);
    step();
    tick = 1'b1;
    step(); tick = 1'b0;
    step(); step();
    check("q_done3", move_done, 1);
    check("q_x2", pos_x, 12);
    check("q_y2", pos_y, 19);
    check("q_dir2", cur_dir, 0);
    step();
`else
    // LEFT from (13,20) to (12,20).
    tick = 1'b1;
    step(); tick = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_addr", rom_addr, 20);
    check("t1_done_c1", move_done, 0);
    step();
    check("t1_done_c2", move_done, 0);
    step();
    check("t1_done_c3", move_done, 1);
    check("t1_busy_done", busy, 0);
    check("t1_x", pos_x, 12);
    check("t1_y", pos_y, 20);
    check("t1_moving", moving, 1);
    step();
    check("t1_done_off", move_done, 0);

    // LEFT into wall at column 11.
    tick = 1'b1;
    step(); tick = 1'b0;
    step(); step();
    check("t2_done", move_done, 1);
    check("t2_x", pos_x, 12);
    check("t2_moving", moving, 0);
    step();
    check("t2_done_off", move_done, 0);

    // Turn UP in IDLE, then move to (12,19).
    dir_valid = 1'b1; dir_in = 2'd0;
    step(); dir_valid = 1'b0;
    check("t3_dir_now", cur_dir, 0);
    tick = 1'b1;
    step(); tick = 1'b0;
    check("t3_addr", rom_addr, 19);
    step(); step();
    check("t3_done", move_done, 1);
    check("t3_x", pos_x, 12);
    check("t3_y", pos_y, 19);
    check("t3_moving", moving, 1);
    step();

    // DOWN with same-cycle dir_valid; tick and RIGHT while busy are dropped.
    dir_valid = 1'b1; dir_in = 2'd1; tick = 1'b1;
    step();
    dir_in = 2'd3;
    step();
    tick = 1'b0; dir_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      pulses += move_done;
      step();
    end
    check("t4_pulses", pulses, 1);
    check("t4_x", pos_x, 12);
    check("t4_y", pos_y, 20);
    check("t4_dir", cur_dir, 1);

    // RIGHT to (13,20) aborted by reset during CK_CUR.
    dir_valid = 1'b1; dir_in = 2'd3; tick = 1'b1;
    step(); dir_valid = 1'b0; tick = 1'b0;
    step();
    check("t5_busy_ck", busy, 1);
    reset = 1'b1;
    step(); reset = 1'b0;
    check("t5_x", pos_x, 13);
    check("t5_y", pos_y, 20);
    check("t5_done", move_done, 0);
    step();
    check("t5_done_after", move_done, 0);
    check("t5_dir", cur_dir, 2);

    // Tick coincident with reset is ignored.
    reset = 1'b1; tick = 1'b1;
    step(); reset = 1'b0; tick = 1'b0;
    check("t6_busy", busy, 0);
    step();
    check("t6_done", move_done, 0);
    check("t6_x", pos_x, 13);
`endif

    // Wrap: LEFT from (0,0) lands on (31,0).
    tick0 = 1'b1;
    step(); tick0 = 1'b0;
    step(); step();
    check("w_done", move_done0, 1);
    check("w_x", pos_x0, 31);
    check("w_y", pos_y0, 0);
    check("w_moving", moving0, 1);
    step();

`ifndef PAC_TURN_QUEUE_EN
    // UP at row 0 blocks without a ROM read.
    dir_valid0 = 1'b1; dir_in0 = 2'd0; tick0 = 1'b1;
    step(); dir_valid0 = 1'b0; tick0 = 1'b0;
    check("oor_done1", move_done0, 1);
    check("oor_busy", busy0, 0);
    check("oor_moving", moving0, 0);
    check("oor_y", pos_y0, 0);
    check("oor_x", pos_x0, 31);
    step();
    check("oor_done_off", move_done0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
